// File: rtl/pkt_arb_pkg.sv
// Shared definitions for the packet arbiter: FSM state encoding and the
// default requester count / per-packet cycle limit.
package pkt_arb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int MAX_CYC_DEF = 16;
  localparam int CNT_W       = 8;  // holds any cycle limit up to 255

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // no owner, arbitrating
    S_HEAD  = 2'd1,  // granted, waiting for the head beat
    S_DATA  = 2'd2,  // head seen, waiting for the tail beat
    S_ABORT = 2'd3   // one-cycle forced termination
  } state_e;

endpackage

// File: rtl/pkt_arbiter_if.sv
// Requester/channel bundle for the packet arbiter.
//   req, in_head, in_tail, in_valid : per-requester request and framing
//   gnt                             : one-hot (or zero) channel owner
//   out_head, out_tail, out_valid   : shared channel framing
//   busy, abort                     : grant held / forced-termination pulse
// master = requester side (drives req/in_*), slave = arbiter.
interface pkt_arbiter_if #(parameter int NREQ = pkt_arb_pkg::NREQ_DEF);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] in_head;
  logic [NREQ-1:0] in_tail;
  logic [NREQ-1:0] in_valid;
  logic [NREQ-1:0] gnt;
  logic            out_head;
  logic            out_tail;
  logic            out_valid;
  logic            busy;
  logic            abort;

  modport master (
    output req, in_head, in_tail, in_valid,
    input  gnt, out_head, out_tail, out_valid, busy, abort
  );

  modport slave (
    input  req, in_head, in_tail, in_valid,
    output gnt, out_head, out_tail, out_valid, busy, abort
  );
endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first set bit of req_i at or after
// start_i, wrapping modulo N.
//   req_i   : request vector
//   start_i : index searched first
//   pick_o  : one-hot selection (zero when no request)
//   idx_o   : binary index of the selection
//   vld_o   : a request was found
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] start_i,
  output logic [N-1:0]  pick_o,
  output logic [PW-1:0] idx_o,
  output logic          vld_o
);

  always_comb begin
    int j;
    j      = 0;
    pick_o = '0;
    idx_o  = '0;
    vld_o  = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start_i) + k) % N;
      if (!vld_o && req_i[j]) begin
        pick_o[j] = 1'b1;
        idx_o     = PW'(j);
        vld_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_arbiter.sv
// Packet-level round-robin arbiter for a shared channel. A grant is held for
// a whole packet (head..tail) and handed straight to the next requester on
// completion. Framing errors or an over-long packet force a one-cycle abort.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : requester/channel bundle (slave side)
module pkt_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int MAX_CYC = MAX_CYC_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  pkt_arbiter_if.slave  bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [PW-1:0]    own_q, own_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PW-1:0]    nxt_own, start;
  logic [NREQ-1:0]  pick;
  logic [PW-1:0]    pick_idx;
  logic             pick_vld;
  logic             bv, bh, bt, err, done;
  logic [CNT_W-1:0] cnt_inc;

  assign nxt_own = (own_q == PW'(NREQ-1)) ? '0 : own_q + 1'b1;
  // Idle arbitration starts at rr_ptr; on completion the search starts just
  // past the finishing owner, so it is considered last.
  assign start   = (state_q == S_IDLE) ? rr_ptr_q : nxt_own;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req_i   (bus.req),
    .start_i (start),
    .pick_o  (pick),
    .idx_o   (pick_idx),
    .vld_o   (pick_vld)
  );

  // Owner's beat; gnt_q is zero outside HEAD/DATA so this masks everything else.
  assign bv = |(bus.in_valid & gnt_q);
  assign bh = |(bus.in_head  & gnt_q);
  assign bt = |(bus.in_tail  & gnt_q);

  always_comb begin
    err = 1'b0;
    case (state_q)
      S_HEAD:  err = bv & ~bh;
      S_DATA:  err = bv & bh;
      default: err = 1'b0;
    endcase
  end

  assign done    = bv & bt & ~err;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // A framing-error beat is the one that triggers the abort; keep it off the
  // channel so downstream never sees a malformed beat.
  assign bus.out_valid = bv & ~err;
  assign bus.out_head  = bh & ~err;
  assign bus.out_tail  = bt & ~err;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = |gnt_q;
  assign bus.abort     = (state_q == S_ABORT);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    own_d    = own_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick;
          own_d   = pick_idx;
          cnt_d   = '0;
          state_d = S_HEAD;
        end
      end
      S_HEAD, S_DATA: begin
        cnt_d = cnt_inc;
        if (done) begin
          rr_ptr_d = nxt_own;
          cnt_d    = '0;
          if (pick_vld) begin
            gnt_d   = pick;
            own_d   = pick_idx;
            state_d = S_HEAD;
          end else begin
            gnt_d   = '0;
            state_d = S_IDLE;
          end
        end else if (err || cnt_inc == CNT_W'(MAX_CYC)) begin
          rr_ptr_d = nxt_own;
          gnt_d    = '0;
          cnt_d    = '0;
          state_d  = S_ABORT;
        end else if (state_q == S_HEAD && bv) begin
          state_d = S_DATA;  // non-error, non-tail beat in HEAD is a head
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      own_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      own_q    <= own_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: doc/pkt_arbiter.md
PKT_ARBITER -- requirements
Module: pkt_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of packet requesters, 2..8.
REQ-002 Parameter MAX_CYC, default 16: maximum grant cycles per packet before forced abort, 2..255.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; asserts immediately, deasserts synchronously to clock.
REQ-005 req  input  NREQ  bit i high: requester i has a packet pending.
REQ-006 in_head, in_tail, in_valid  input  NREQ each  per-requester framing: head beat, tail beat, beat valid.
REQ-007 gnt  output  NREQ  one-hot or zero; owner of the shared channel.
REQ-008 out_head, out_tail, out_valid  output  1 each  shared channel framing.
REQ-009 busy  output  1  high while any grant is held.
REQ-010 abort  output  1  one-cycle pulse on forced packet termination.

Function
REQ-011 The state machine SHALL have states IDLE, HEAD (granted, awaiting head beat), DATA (head seen, awaiting tail) and ABORT.
REQ-012 IDLE with any req bit set SHALL register a grant to the first set requester at or after rr_ptr, modulo NREQ; state moves to HEAD, gnt valid next cycle.
REQ-013 out_valid/out_head/out_tail SHALL equal the granted requester's in_valid/in_head/in_tail ANDed with its gnt bit, combinationally (zero latency); all zero when gnt is zero.
REQ-014 In HEAD, a beat with valid&head&!tail SHALL move to DATA; valid&head&tail (single-beat packet) SHALL complete the packet.
REQ-015 In HEAD, a beat with valid&!head SHALL be a protocol error: move to ABORT.
REQ-016 In DATA, a beat with valid&tail SHALL complete the packet; valid&head SHALL be a protocol error: move to ABORT.
REQ-017 On completion, rr_ptr SHALL be set to owner+1 modulo NREQ, and in the same cycle the next owner SHALL be selected from req per REQ-012, giving back-to-back grants with no idle cycle; if no req is set, gnt clears and state returns to IDLE.
REQ-018 The completing owner SHALL be eligible again only after all other requesting indices in round-robin order.
REQ-019 A cycle counter SHALL clear on each new grant and increment each granted cycle; reaching MAX_CYC without completion SHALL move to ABORT.
REQ-020 ABORT SHALL last exactly one cycle: abort=1, gnt=0, out_* forced 0, rr_ptr advanced past the aborted owner, then IDLE.
REQ-021 Deassertion of req by the owner while granted SHALL be ignored; the grant is released only by completion or abort.
REQ-022 Beats from non-granted requesters SHALL never reach out_*.
REQ-023 busy SHALL equal OR of gnt.
REQ-024 At most one gnt bit SHALL ever be high.

Reset
REQ-025 Reset assertion SHALL force state IDLE, gnt=0, rr_ptr=0, counter=0, abort=0, busy=0 and out_*=0 asynchronously, regardless of any packet in progress.
REQ-026 After reset deassertion the first arbitration SHALL start from index 0.

Structure
REQ-027 State encodings (IDLE, HEAD, DATA, ABORT) and the default NREQ and MAX_CYC values SHALL reside in a shared package pkt_arb_pkg.
REQ-028 Round-robin selection SHALL be a sub-module rr_pick (inputs req vector and start pointer; output one-hot pick).

Verification
REQ-029 NREQ=4, req=4'b0101 from reset, each sends head,data,tail -> gnt 0001 for 3 beats, then 0100 on the next cycle without gap, rr_ptr=3.
REQ-030 Requester 2 sends valid&head&tail in one cycle -> packet completes that cycle, out_head=out_tail=out_valid=1 for one cycle.
REQ-031 Owner holds HEAD/DATA without tail for 16 granted cycles -> abort=1 on cycle 17, gnt=0, next grant to the following requester.
REQ-032 Owner issues valid&!head as first beat -> one-cycle abort, out_valid=0 for that beat.
REQ-033 reset driven low mid-packet in DATA -> gnt=0, out_*=0 immediately without clock; after release, req=4'b1000 -> gnt=4'b1000 one cycle later.
REQ-034 All four requesters continuously requesting single-beat packets -> grants rotate 0,1,2,3,0 with one packet per cycle, never two gnt bits high.
